// File: rtl/radix4_pkg.sv
`default_nettype none
// ============================================================================
// Module      : radix4_pkg
// Description : Shared FSM state codes, Booth digit type and the radix-4
//               Booth recoding function for the sequential multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
package radix4_pkg;

    // Controller state codes
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Radix-4 Booth digit: selects 0, +A, +2A, -A or -2A
    typedef enum logic [2:0] {
        ZERO = 3'd0,
        P1   = 3'd1,
        P2   = 3'd2,
        M1   = 3'd3,
        M2   = 3'd4
    } booth_digit_e;

    // Recode one overlapping group {b[i+1], b[i], b[i-1]} into a Booth digit
    function automatic booth_digit_e booth_digit(input logic [2:0] grp);
        booth_digit_e d;
        case (grp)
            3'b000, 3'b111: d = ZERO;
            3'b001, 3'b010: d = P1;
            3'b011:         d = P2;
            3'b100:         d = M2;
            3'b101, 3'b110: d = M1;
            default:        d = ZERO;
        endcase
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/radix4_booth_pp_sel.sv
`default_nettype none
// ============================================================================
// Module      : radix4_booth_pp_sel
// Description : Combinational partial-product selector. Produces the
//               double-width two's complement value digit * A.
// Revision    : 1.0 - initial release
// ============================================================================
module radix4_booth_pp_sel
    import radix4_pkg::*;
#(
    parameter int W2 = 34
) (
    input  booth_digit_e         digit_i,
    input  logic [W2-1:0]        a_i,
    output logic [2*W2-1:0]      pp_o
);

    localparam logic [2*W2-1:0] C_ONE = {{(2*W2-1){1'b0}}, 1'b1};

    logic [2*W2-1:0] w_a_wide;
    logic [2*W2-1:0] w_a_dbl;

    // A is already in W2-bit two's complement form, so sign-extend it to the accumulator width
    assign w_a_wide = {{W2{a_i[W2-1]}}, a_i};
    assign w_a_dbl  = {w_a_wide[2*W2-2:0], 1'b0};

    // Select the multiple of A; negation is invert-plus-one
    always_comb begin
        pp_o = '0;
        case (digit_i)
            ZERO:    pp_o = '0;
            P1:      pp_o = w_a_wide;
            P2:      pp_o = w_a_dbl;
            M1:      pp_o = ~w_a_wide + C_ONE;
            M2:      pp_o = ~w_a_dbl + C_ONE;
            default: pp_o = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/radix4_booth_seq_mult.sv
`default_nettype none
// ============================================================================
// Module      : radix4_booth_seq_mult
// Description : Sequential radix-4 Booth multiplier with valid/ready on both
//               sides, per-transaction signed/unsigned mode and a held result.
//               One Booth digit is retired per CALC cycle; timing is fixed.
// Revision    : 1.0 - initial release
// ============================================================================
module radix4_booth_seq_mult
    import radix4_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
);

    // Two guard bits let an unsigned operand with its MSB set still be a
    // positive two's complement number, at the cost of one extra digit.
    localparam int W2    = WIDTH + 2;
    localparam int N     = W2 / 2;
    localparam int CNT_W = $clog2(N) + 1;

    generate
        if (((WIDTH % 2) != 0) || (WIDTH < 4)) begin : g_width_check
            $error("radix4_booth_seq_mult: WIDTH must be even and >= 4");
        end
    endgenerate

    logic [1:0]           state_q, state_d;
    logic [W2-1:0]        a_q, a_d;
    logic [W2:0]          b_q, b_d;      // bit 0 holds the implicit B[-1]
    logic [2*W2-1:0]      acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;

    logic [W2-1:0]        w_a_ext;
    logic [W2-1:0]        w_b_ext;
    booth_digit_e         w_digit;
    logic [2*W2-1:0]      w_pp;
    logic [2*W2-1:0]      w_pp_shifted;
    logic                 unused_acc_hi;

    // Extend operands to W2 bits according to the requested signedness
    always_comb begin
        w_a_ext = {2'b00, multiplicand};
        w_b_ext = {2'b00, multiplier};
        if (signed_mode) begin
            w_a_ext = {{2{multiplicand[WIDTH-1]}}, multiplicand};
            w_b_ext = {{2{multiplier[WIDTH-1]}}, multiplier};
        end
    end

    // The low three bits of the B shift register are always the current Booth group
    assign w_digit = booth_digit(b_q[2:0]);

    radix4_booth_pp_sel #(
        .W2      (W2)
    ) u_pp_sel (
        .digit_i (w_digit),
        .a_i     (a_q),
        .pp_o    (w_pp)
    );

    // Weight the partial product by 4^i, i being the digit index
    assign w_pp_shifted = w_pp << {cnt_q, 1'b0};

    // Controller and datapath next-state logic
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = w_a_ext;
                    b_d     = {w_b_ext, 1'b0};
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (cnt_q == CNT_W'(N)) begin
                    // The product is exact in 2*WIDTH bits; the guard bits are dropped
                    prod_d  = acc_q[2*WIDTH-1:0];
                    state_d = S_DONE;
                end else begin
                    acc_d = acc_q + w_pp_shifted;
                    b_d   = {{2{b_q[W2]}}, b_q[W2:2]};
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset discards any in-flight operation
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign product   = prod_q;

    assign unused_acc_hi = ^acc_q[2*W2-1:2*WIDTH];

endmodule
`default_nettype wire

// File: tb/tb_radix4_booth_seq_mult.sv
`default_nettype none
// ============================================================================
// Module      : tb_radix4_booth_seq_mult
// Description : Self-checking bench for the radix-4 Booth multiplier at
//               WIDTH=32 and WIDTH=8 against a plain-arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_radix4_booth_seq_mult;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        iv32, ir32, sm32, ov32, or32;
    logic [31:0] a32, b32;
    logic [63:0] p32;

    logic        iv8, ir8, sm8, ov8, or8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;

    int checks = 0;
    int errors = 0;

    radix4_booth_seq_mult #(.WIDTH(32)) dut32 (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (iv32),
        .in_ready     (ir32),
        .signed_mode  (sm32),
        .multiplicand (a32),
        .multiplier   (b32),
        .out_valid    (ov32),
        .out_ready    (or32),
        .product      (p32)
    );

    radix4_booth_seq_mult #(.WIDTH(8)) dut8 (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (iv8),
        .in_ready     (ir8),
        .signed_mode  (sm8),
        .multiplicand (a8),
        .multiplier   (b8),
        .out_valid    (ov8),
        .out_ready    (or8),
        .product      (p8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: interpret the low w bits as signed or unsigned and multiply
    function automatic logic [63:0] ref_mul(input int w, input logic s,
                                            input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] r;
        logic [31:0] am, bm;
        am = (w == 8) ? (a & 32'h0000_00FF) : a;
        bm = (w == 8) ? (b & 32'h0000_00FF) : b;
        sa = longint'({32'b0, am});
        sb = longint'({32'b0, bm});
        if (s && am[w-1]) sa = sa - (longint'(1) << w);
        if (s && bm[w-1]) sb = sb - (longint'(1) << w);
        r = 64'(sa * sb);
        if (w == 8) r = r & 64'h0000_0000_0000_FFFF;
        return r;
    endfunction

    function automatic logic get_ir(input int w);
        return (w == 8) ? ir8 : ir32;
    endfunction

    function automatic logic get_ov(input int w);
        return (w == 8) ? ov8 : ov32;
    endfunction

    function automatic logic [63:0] get_p(input int w);
        return (w == 8) ? {48'b0, p8} : p32;
    endfunction

    task automatic drive_in(input int w, input logic v, input logic s,
                            input logic [31:0] a, input logic [31:0] b);
        if (w == 8) begin
            iv8 = v; sm8 = s; a8 = a[7:0]; b8 = b[7:0];
        end else begin
            iv32 = v; sm32 = s; a32 = a; b32 = b;
        end
    endtask

    task automatic drive_or(input int w, input logic v);
        if (w == 8) or8 = v;
        else        or32 = v;
    endtask

    // One full transaction: accept, latency, result, optional stall, consume
    task automatic run_op(input int w, input logic s, input logic [31:0] a,
                          input logic [31:0] b, input string tag, input int hold);
        logic [63:0] exp;
        int lat;
        exp = ref_mul(w, s, a, b);
        @(negedge clk);
        chk({tag, ".in_ready_idle"}, 64'(get_ir(w)), 64'd1);
        drive_in(w, 1'b1, s, a, b);
        @(posedge clk); #1;
        // Operands changed after accept must be ignored
        drive_in(w, 1'b0, 1'($urandom), $urandom, $urandom);
        lat = 0;
        while (!get_ov(w) && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, ".latency"}, 64'(lat), 64'(w / 2 + 2));
        chk({tag, ".product"}, get_p(w), exp);
        chk({tag, ".in_ready_done"}, 64'(get_ir(w)), 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            drive_in(w, 1'b1, 1'($urandom), $urandom, $urandom);
            @(posedge clk); #1;
            chk({tag, ".hold_valid"}, 64'(get_ov(w)), 64'd1);
            chk({tag, ".hold_product"}, get_p(w), exp);
            chk({tag, ".hold_in_ready"}, 64'(get_ir(w)), 64'd0);
        end
        @(negedge clk);
        drive_in(w, 1'b0, 1'b0, 32'd0, 32'd0);
        drive_or(w, 1'b1);
        @(posedge clk); #1;
        drive_or(w, 1'b0);
        chk({tag, ".consumed_valid"}, 64'(get_ov(w)), 64'd0);
        chk({tag, ".consumed_in_ready"}, 64'(get_ir(w)), 64'd1);
        chk({tag, ".product_held"}, get_p(w), exp);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rs;
        rst_n = 1'b0;
        drive_in(32, 1'b0, 1'b0, 32'd0, 32'd0);
        drive_in(8, 1'b0, 1'b0, 32'd0, 32'd0);
        or32 = 1'b0;
        or8  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.in_ready32", 64'(ir32), 64'd1);
        chk("reset.out_valid32", 64'(ov32), 64'd0);
        chk("reset.product32", p32, 64'd0);
        chk("reset.in_ready8", 64'(ir8), 64'd1);
        chk("reset.product8", {48'b0, p8}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed WIDTH=32 cases
        run_op(32, 1'b1, 32'd553524, 32'd840, "t1", 0);
        run_op(32, 1'b1, -32'sd1199060305, -32'sd2005095693, "t2a", 0);
        run_op(32, 1'b1, -32'sd259, 32'd553524, "t2b", 0);
        run_op(32, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "t3u", 0);
        run_op(32, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "t3s", 0);
        run_op(32, 1'b1, 32'h8000_0000, 32'h8000_0000, "minmin", 0);
        run_op(32, 1'b0, 32'd123456789, 32'd987654, "t4", 10);

        // Reset in the middle of a calculation
        @(negedge clk);
        drive_in(32, 1'b1, 1'b1, 32'd77, 32'd99);
        @(posedge clk); #1;
        drive_in(32, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("t5.in_ready", 64'(ir32), 64'd1);
        chk("t5.out_valid", 64'(ov32), 64'd0);
        chk("t5.product", p32, 64'd0);
        run_op(32, 1'b1, 32'd0, 32'd1348760118, "t5.next", 0);

        // Directed WIDTH=8 cases
        run_op(8, 1'b1, 32'h80, 32'h80, "t6a", 0);
        run_op(8, 1'b0, 32'hFF, 32'hFF, "t6b", 0);
        run_op(8, 1'b1, 32'd5, 32'd0, "t6c", 0);
        run_op(8, 1'b1, 32'h7F, 32'h80, "t6d", 2);

        // Randomized operands and modes
        for (int i = 0; i < 12; i++) begin
            ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
            run_op(32, rs, ra, rb, "rnd32", 0);
        end
        for (int i = 0; i < 12; i++) begin
            ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
            run_op(8, rs, ra, rb, "rnd8", 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
